// File: rtl/pe_pkg.sv
// Shared definitions for the PE stream controller: default geometry,
// PE mode encodings, the controller state type and a mode helper.
package pe_pkg;

  localparam int PE_WORD_LEN = 16;
  localparam int PE_NEU_IN   = 8;
  localparam int PE_NEU_OUT  = 4;
  localparam int PE_LAT_DEF  = 2;

  localparam logic [1:0] MODE_WUPD = 2'b00;
  localparam logic [1:0] MODE_MVM  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_D,
    FIRE,
    WAIT,
    DRAIN
  } pe_state_e;

  // The PE only understands weight-update and MVM; any other request is run as MVM.
  function automatic logic [1:0] mode_sanitize(input logic [1:0] raw);
    return (raw == MODE_WUPD) ? MODE_WUPD : MODE_MVM;
  endfunction

endpackage

// File: rtl/pe_q_serializer.sv
// Captures the PE result bus in one shot and streams it out word by word
// on a valid/ready interface, flagging the final word with m_last.
module pe_q_serializer
  import pe_pkg::*;
#(
  parameter int WORD_LEN = PE_WORD_LEN,
  parameter int NQ       = (PE_NEU_IN * PE_NEU_OUT) / 2,
  parameter int IDX_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   capture,
  input  logic [WORD_LEN*NQ-1:0] q_bus,
  input  logic [IDX_W-1:0]       last_idx,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [WORD_LEN-1:0]    m_data,
  output logic                   m_last,
  output logic                   done
);

  logic [WORD_LEN-1:0] q_mem [NQ];
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    last_q;
  logic                at_last;
  logic                m_fire;

  assign at_last = (rd_idx == last_q);
  assign m_fire  = m_valid & m_ready;
  assign done    = m_fire & at_last;

  // Snapshot the result bus on capture, then walk the read index one step per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      rd_idx  <= '0;
      last_q  <= '0;
      for (int k = 0; k < NQ; k++) begin
        q_mem[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NQ; k++) begin
        q_mem[k] <= q_bus[k*WORD_LEN +: WORD_LEN];
      end
      rd_idx  <= '0;
      last_q  <= last_idx;
      m_valid <= 1'b1;
    end else if (m_fire) begin
      if (at_last) begin
        m_valid <= 1'b0;
      end else begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Present the current word only while valid so the bus reads zero when idle.
  always_comb begin
    m_data = '0;
    m_last = 1'b0;
    if (m_valid) begin
      m_data = q_mem[rd_idx];
      m_last = at_last;
    end
  end

endmodule

// File: rtl/pe_stream_ctrl.sv
// Stream front end for one PE: assembles a frame of weights and neurons
// from a word stream, fires the PE once, waits out its latency and hands
// the result to the serializer for draining.
module pe_stream_ctrl
  import pe_pkg::*;
#(
  parameter int WORD_LEN = PE_WORD_LEN,
  parameter int NEU_IN   = PE_NEU_IN,
  parameter int NEU_OUT  = PE_NEU_OUT,
  parameter int PE_LAT   = PE_LAT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [WORD_LEN-1:0]                   s_data,
  input  logic [1:0]                            s_mode,
  output logic                                  pe_ce,
  output logic [1:0]                            pe_mode,
  output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]    pe_W,
  output logic [WORD_LEN*NEU_IN-1:0]            pe_D,
  input  logic [WORD_LEN*NEU_IN*NEU_OUT/2-1:0]  pe_Q,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [WORD_LEN-1:0]                   m_data,
  output logic                                  m_last
);

  localparam int NW     = NEU_IN * NEU_OUT;
  localparam int NQ     = NW / 2;
  localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int DCNT_W = (NEU_IN > 1) ? $clog2(NEU_IN) : 1;
  localparam int WT_W   = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam int IDX_W  = (NQ > 1) ? $clog2(NQ) : 1;

  localparam logic [WCNT_W-1:0] W_LAST  = WCNT_W'(NW - 1);
  localparam logic [DCNT_W-1:0] D_LAST  = DCNT_W'(NEU_IN - 1);
  localparam logic [WT_W-1:0]   WT_LOAD = WT_W'(PE_LAT - 1);

  pe_state_e state;
  pe_state_e state_next;

  logic [WORD_LEN-1:0] w_mem [NW];
  logic [WORD_LEN-1:0] d_mem [NEU_IN];
  logic [WCNT_W-1:0]   w_cnt;
  logic [DCNT_W-1:0]   d_cnt;
  logic [WT_W-1:0]     wait_cnt;
  logic                s_ready_q;
  logic                s_fire;
  logic                capture;
  logic                drain_done;
  logic [IDX_W-1:0]    last_idx;

  assign s_ready = s_ready_q;
  assign s_fire  = s_valid & s_ready_q;

  // MVM produces one word per output neuron; weight update returns half the synapse array.
  assign last_idx = (pe_mode == MODE_MVM) ? IDX_W'(NEU_OUT - 1) : IDX_W'(NQ - 1);

  for (genvar k = 0; k < NW; k++) begin : g_pack_w
    assign pe_W[k*WORD_LEN +: WORD_LEN] = w_mem[k];
  end

  for (genvar j = 0; j < NEU_IN; j++) begin : g_pack_d
    assign pe_D[j*WORD_LEN +: WORD_LEN] = d_mem[j];
  end

  // State register; reset drops any partial frame straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the single-cycle PE enable and the capture strobe.
  always_comb begin
    state_next = state;
    pe_ce      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (s_fire) begin
          state_next = LOAD_W;
        end
      end
      LOAD_W: begin
        if (s_fire && (w_cnt == W_LAST)) begin
          state_next = LOAD_D;
        end
      end
      LOAD_D: begin
        if (s_fire && (d_cnt == D_LAST)) begin
          state_next = FIRE;
        end
      end
      FIRE: begin
        pe_ce      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          capture    = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ready is registered from the upcoming state so it stays low through reset and rises one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q <= 1'b0;
    end else begin
      s_ready_q <= (state_next == IDLE) || (state_next == LOAD_W) || (state_next == LOAD_D);
    end
  end

  // Word loaders: only accepted words move the counters or touch the PE operand buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt   <= '0;
      d_cnt   <= '0;
      pe_mode <= MODE_WUPD;
      for (int k = 0; k < NW; k++) begin
        w_mem[k] <= '0;
      end
      for (int j = 0; j < NEU_IN; j++) begin
        d_mem[j] <= '0;
      end
    end else if (s_fire) begin
      case (state)
        IDLE: begin
          w_mem[0] <= s_data;
          w_cnt    <= WCNT_W'(1);
          pe_mode  <= mode_sanitize(s_mode);
        end
        LOAD_W: begin
          w_mem[w_cnt] <= s_data;
          if (w_cnt == W_LAST) begin
            w_cnt <= '0;
            d_cnt <= '0;
          end else begin
            w_cnt <= w_cnt + 1'b1;
          end
        end
        LOAD_D: begin
          d_mem[d_cnt] <= s_data;
          if (d_cnt == D_LAST) begin
            d_cnt <= '0;
          end else begin
            d_cnt <= d_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Latency down-counter: armed in FIRE, reaches zero in the last WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == FIRE) begin
      wait_cnt <= WT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  pe_q_serializer #(
    .WORD_LEN (WORD_LEN),
    .NQ       (NQ),
    .IDX_W    (IDX_W)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .q_bus    (pe_Q),
    .last_idx (last_idx),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .done     (drain_done)
  );

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Self-checking bench for pe_stream_ctrl: random and directed frames, a PE
// stub honouring the pipeline latency, and a scoreboard-driven monitor.
module tb_pe_stream_ctrl;

  localparam int WL  = 16;
  localparam int NI  = 8;
  localparam int NO  = 4;
  localparam int LAT = 2;
  localparam int NW  = NI * NO;
  localparam int NQ  = NW / 2;
  localparam int FRAME = NW + NI;

  typedef struct {
    logic [WL-1:0] data;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [WL-1:0]     s_data;
  logic [1:0]        s_mode;
  logic              pe_ce;
  logic [1:0]        pe_mode;
  logic [WL*NW-1:0]  pe_W;
  logic [WL*NI-1:0]  pe_D;
  logic [WL*NQ-1:0]  pe_Q;
  logic              m_valid;
  logic              m_ready;
  logic [WL-1:0]     m_data;
  logic              m_last;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            fire_cyc = 0;
  int            ce_count = 0;
  int            fires_expected = 0;
  int            rdy_mode = 2;
  logic [WL-1:0] mod_w [NW];
  logic [WL-1:0] mod_d [NI];
  logic [1:0]    mod_mode;

  pe_stream_ctrl #(
    .WORD_LEN (WL),
    .NEU_IN   (NI),
    .NEU_OUT  (NO),
    .PE_LAT   (LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_mode  (s_mode),
    .pe_ce   (pe_ce),
    .pe_mode (pe_mode),
    .pe_W    (pe_W),
    .pe_D    (pe_D),
    .pe_Q    (pe_Q),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [511:0] packW();
    logic [511:0] v = '0;
    for (int k = 0; k < NW; k++) v[k*WL +: WL] = mod_w[k];
    return v;
  endfunction

  function automatic logic [511:0] packD();
    logic [511:0] v = '0;
    for (int j = 0; j < NI; j++) v[j*WL +: WL] = mod_d[j];
    return v;
  endfunction

  // Cycle counter used for latency measurement.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // PE stub: results are only meaningful for the one cycle that ends PE_LAT cycles after pe_ce.
  initial begin
    int cnt = -1;
    for (int i = 0; i < NQ; i++) pe_Q[i*WL +: WL] = 16'(32'h5000 + i);
    forever begin
      @(negedge clk);
      if (pe_ce === 1'b1) begin
        cnt = LAT;
        ce_count++;
        fire_cyc = cyc;
      end else if (cnt > 0) begin
        cnt--;
      end else begin
        cnt = -1;
      end
      for (int i = 0; i < NQ; i++) begin
        pe_Q[i*WL +: WL] = (cnt == 0) ? 16'(32'hA000 + i) : 16'(32'h5000 + i);
      end
    end
  end

  // Sink ready generator: 0 = always ready, 1 = random, otherwise held low.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    logic          prev_valid = 1'b0;
    logic          hold = 1'b0;
    logic          last_hs = 1'b0;
    logic [WL-1:0] hold_data = '0;
    logic          hold_last = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (last_hs) begin
          checkOutput("m_valid_after_last", 512'(m_valid), 512'(0));
          last_hs = 1'b0;
        end
        if (hold) begin
          checkOutput("stall_valid", 512'(m_valid), 512'(1));
          checkOutput("stall_data", 512'(m_data), 512'(hold_data));
          checkOutput("stall_last", 512'(m_last), 512'(hold_last));
          hold = 1'b0;
        end
        if (m_valid && !prev_valid) begin
          checkOutput("first_valid_latency", 512'(cyc - fire_cyc), 512'(LAT + 1));
        end
        if (m_valid) checkOutput("s_ready_low_in_drain", 512'(s_ready), 512'(0));
        if (pe_ce) checkOutput("s_ready_low_at_fire", 512'(s_ready), 512'(0));
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_m_valid", 512'(m_valid), 512'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("m_data", 512'(m_data), 512'(e.data));
            checkOutput("m_last", 512'(m_last), 512'(e.last));
            if (e.last) last_hs = 1'b1;
          end
        end else if (m_valid) begin
          hold      = 1'b1;
          hold_data = m_data;
          hold_last = m_last;
        end
        prev_valid = m_valid;
      end else begin
        prev_valid = 1'b0;
        hold       = 1'b0;
        last_hs    = 1'b0;
      end
    end
  end

  task automatic sendWord(input logic [WL-1:0] data, input logic [1:0] mode);
    int   guard = 0;
    logic hs = 1'b0;
    s_valid = 1'b1;
    s_data  = data;
    s_mode  = mode;
    while (!hs && guard < 200) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!hs) checkOutput("s_ready_timeout", 512'(s_ready), 512'(1));
    s_valid = 1'b0;
  endtask

  // Drives nwords of a frame; a complete frame also pushes the expected PE results.
  task automatic applyStimulus(input logic [1:0] mode, input bit directed, input int nwords, input bit gaps);
    int n;
    for (int i = 0; i < nwords; i++) begin
      logic [WL-1:0] w;
      if (directed) w = (i < NW) ? WL'(i + 1) : 16'h1000;
      else w = WL'($urandom);
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          s_data = WL'($urandom);
          s_mode = 2'($urandom);
          @(posedge clk);
          #1;
        end
      end
      sendWord(w, (i == 0) ? mode : 2'($urandom));
      if (i < NW) mod_w[i] = w;
      else mod_d[i - NW] = w;
      if (i == 0) mod_mode = (mode == 2'b00) ? 2'b00 : 2'b01;
    end
    if (nwords == FRAME) begin
      fires_expected++;
      n = (mod_mode == 2'b00) ? NQ : NO;
      for (int i = 0; i < n; i++) begin
        exp_t e;
        e.data = 16'(32'hA000 + i);
        e.last = (i == n - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 512'(exp_q.size()), 512'(0));
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkFrameState();
    checkOutput("pe_W", pe_W, packW());
    checkOutput("pe_D", 512'(pe_D), packD());
    checkOutput("pe_mode", 512'(pe_mode), 512'(mod_mode));
    checkOutput("pe_ce_count", 512'(ce_count), 512'(fires_expected));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_s_ready"}, 512'(s_ready), 512'(0));
    checkOutput({tag, "_pe_ce"}, 512'(pe_ce), 512'(0));
    checkOutput({tag, "_pe_mode"}, 512'(pe_mode), 512'(0));
    checkOutput({tag, "_pe_W"}, pe_W, 512'(0));
    checkOutput({tag, "_pe_D"}, 512'(pe_D), 512'(0));
    checkOutput({tag, "_m_valid"}, 512'(m_valid), 512'(0));
    checkOutput({tag, "_m_last"}, 512'(m_last), 512'(0));
    checkOutput({tag, "_m_data"}, 512'(m_data), 512'(0));
  endtask

  // Watchdog so the run always ends even if the design wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_mode  = 2'b00;
    mod_mode = 2'b00;
    for (int k = 0; k < NW; k++) mod_w[k] = '0;
    for (int j = 0; j < NI; j++) mod_d[j] = '0;

    $display("[TB] reset phase");
    repeat (3) @(negedge clk);
    checkResetState("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s_ready_after_reset", 512'(s_ready), 512'(1));

    $display("[TB] directed MVM frame");
    rdy_mode = 0;
    applyStimulus(2'b01, 1'b1, FRAME, 1'b0);
    waitDrain();
    checkFrameState();

    $display("[TB] weight-update frame with random backpressure");
    rdy_mode = 1;
    applyStimulus(2'b00, 1'b0, FRAME, 1'b1);
    waitDrain();
    checkFrameState();

    $display("[TB] mode 11 frame");
    applyStimulus(2'b11, 1'b0, FRAME, 1'b1);
    waitDrain();
    checkFrameState();

    $display("[TB] directed stall on word 2");
    rdy_mode = 2;
    applyStimulus(2'b01, 1'b1, FRAME, 1'b1);
    guard = 0;
    while (!m_valid && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!m_valid) checkOutput("m_valid_timeout", 512'(m_valid), 512'(1));
    rdy_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rdy_mode = 2;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_word2", 512'(m_data), 512'(16'hA002));
      checkOutput("stall_s_ready", 512'(s_ready), 512'(0));
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    waitDrain();
    checkFrameState();

    $display("[TB] reset mid-frame");
    applyStimulus(2'b01, 1'b0, 20, 1'b1);
    rst_n = 1'b0;
    #1;
    checkResetState("abort");
    for (int k = 0; k < NW; k++) mod_w[k] = '0;
    for (int j = 0; j < NI; j++) mod_d[j] = '0;
    mod_mode = 2'b00;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_no_fire", 512'(ce_count), 512'(fires_expected));
    applyStimulus(2'b01, 1'b1, FRAME, 1'b0);
    waitDrain();
    checkFrameState();

    $display("[TB] random frames");
    rdy_mode = 1;
    for (int f = 0; f < 4; f++) begin
      applyStimulus(2'($urandom), 1'b0, FRAME, 1'b1);
      waitDrain();
      checkFrameState();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
